hilo_divider: RTL

Iterative 32-bit divider that owns the HI/LO register pair for the mips32 EX stage. `div`/`divu` start a multi-cycle divide. `mfhi`/`mflo` read the results back and stall the pipeline while a divide is in flight. It sits beside the ALU in EX, and its `Stall` output feeds the pipeline hazard logic.

---
 rtl/hilo_divider.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/hilo_divider.sv
// HI/LO register pair with an iterative restoring divider for the EX stage.
// div/divu run WIDTH+1 cycles; mfhi/mflo stall while a divide is in flight.
module hilo_divider #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             ReadHi,
    input  logic             ReadLo,
    output logic             Busy,
    output logic             Stall,
    output logic [WIDTH-1:0] HiLoOut,
    output logic [WIDTH-1:0] Hi,
    output logic [WIDTH-1:0] Lo,
    output logic             DivByZero
);

    localparam int unsigned CountW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned RemW   = WIDTH + 1;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StFix  = 2'd2
    } stateT;

    stateT state;
    stateT stateNext;

    logic              accept;
    logic              runStep;
    logic              fixStep;

    logic [WIDTH-1:0]  latchedA;
    logic              latchedBZero;
    logic              signA;
    logic              signB;
    logic [WIDTH-1:0]  absB;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  quo;
    logic [CountW-1:0] count;

    logic              startSignA;
    logic              startSignB;
    logic [WIDTH-1:0]  startAbsA;
    logic [WIDTH-1:0]  startAbsB;

    logic [RemW-1:0]   remShift;
    logic [RemW-1:0]   remSub;
    logic              fits;
    logic [WIDTH-1:0]  remStep;
    logic [WIDTH-1:0]  quoStep;

    logic [WIDTH-1:0]  negQuo;
    logic [WIDTH-1:0]  negRem;

    // State register
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and per-state strobes
    always_comb begin
        stateNext = state;
        accept    = 1'b0;
        runStep   = 1'b0;
        fixStep   = 1'b0;
        case (state)
            StIdle: begin
                if (Start) begin
                    accept    = 1'b1;
                    stateNext = StRun;
                end
            end
            StRun: begin
                runStep = 1'b1;
                if (count == CountW'(WIDTH - 1)) begin
                    stateNext = StFix;
                end
            end
            StFix: begin
                fixStep   = 1'b1;
                stateNext = StIdle;
            end
            default: begin
                stateNext = StIdle;
            end
        endcase
    end

    // Operand signs and magnitudes captured on accept
    always_comb begin
        startSignA = A[WIDTH-1] & Signed;
        startSignB = B[WIDTH-1] & Signed;
        startAbsA  = startSignA ? (~A + WIDTH'(1)) : A;
        startAbsB  = startSignB ? (~B + WIDTH'(1)) : B;
    end

    // One restoring step; the borrow out of the WIDTH+1 bit subtract is the compare
    always_comb begin
        remShift = {rem, quo[WIDTH-1]};
        remSub   = remShift - {1'b0, absB};
        fits     = ~remSub[WIDTH];
        remStep  = fits ? remSub[WIDTH-1:0] : remShift[WIDTH-1:0];
        quoStep  = {quo[WIDTH-2:0], fits};
    end

    always_comb begin
        negQuo = ~quo + WIDTH'(1);
        negRem = ~rem + WIDTH'(1);
    end

    // Datapath and architectural HI/LO; HI/LO only move in FIX or on reset
    always_ff @(posedge Clock) begin
        if (Reset) begin
            latchedA     <= '0;
            latchedBZero <= 1'b0;
            signA        <= 1'b0;
            signB        <= 1'b0;
            absB         <= '0;
            rem          <= '0;
            quo          <= '0;
            count        <= '0;
            Hi           <= '0;
            Lo           <= '0;
            DivByZero    <= 1'b0;
        end else begin
            if (accept) begin
                latchedA     <= A;
                latchedBZero <= (B == '0);
                signA        <= startSignA;
                signB        <= startSignB;
                absB         <= startAbsB;
                rem          <= '0;
                quo          <= startAbsA;
                count        <= '0;
                DivByZero    <= 1'b0;
            end
            if (runStep) begin
                rem   <= remStep;
                quo   <= quoStep;
                count <= count + CountW'(1);
            end
            if (fixStep) begin
                if (latchedBZero) begin
                    Lo        <= '1;
                    Hi        <= latchedA;
                    DivByZero <= 1'b1;
                end else begin
                    Lo <= (signA ^ signB) ? negQuo : quo;
                    Hi <= signA ? negRem : rem;
                end
            end
        end
    end

    // Hazard-facing outputs are combinational so the stall lands in the same cycle
    always_comb begin
        Busy    = (state != StIdle);
        Stall   = Busy & (Start | ReadHi | ReadLo);
        HiLoOut = ReadHi ? Hi : Lo;
    end

endmodule
